// File: rtl/fifo_wptr_wrap_ctrl_pkg.sv
// Shared definitions for the FIFO write/read pointer controllers.
//  - PTR_MAX_W / ptr_max_t : widest pointer the Gray helpers handle; callers
//    zero-extend into it and truncate the result back to their own width.
//  - bin2gray / gray2bin   : pointer code conversion for clock-domain crossing.
//  - depth_ok / ndly_ok    : elaboration-time parameter legality rules.
//  - wflags_t              : registered write-side status flags.
package fifo_wptr_wrap_ctrl_pkg;

  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // DEPTH must be a power of two, at least 4, and fit the Gray helpers.
  function automatic bit depth_ok(input int d);
    return (d >= 4) && ((d & (d - 1)) == 0) && (d < (1 << (PTR_MAX_W - 1)));
  endfunction

  function automatic bit ndly_ok(input int n);
    return (n >= 1) && (n <= 4);
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic wrap_pulse;
    logic overflow;
    logic ptr_err;
  } wflags_t;

endpackage

// File: rtl/fifo_wptr_wrap_ctrl_if.sv
// Bus between the write-side pointer controller and its user.
//  Handshake: a write happens in exactly the cycles where wr_en=1 and
//  wr_accept=1 at the clk_w edge. wr_accept is combinational (wr_en & ~full)
//  and full is registered, so a requester may drop or re-raise wr_en freely;
//  there is no obligation to hold wr_en until accepted.
//  Inputs to the controller : wr_en, rptr_sync, af_thr_ld, af_thr, clr_err
//  Outputs of the controller: wr_accept, waddr, wptr, wptr_gray, level, full,
//                             almost_full, wrap_pulse, wrap_dly, overflow, ptr_err
//  master = FIFO user / testbench, slave = the controller.
interface fifo_wptr_wrap_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW:0]   rptr_sync;
  logic          af_thr_ld;
  logic [AW:0]   af_thr;
  logic          clr_err;

  logic          wr_accept;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   level;
  logic          full;
  logic          almost_full;
  logic          wrap_pulse;
  logic          wrap_dly;
  logic          overflow;
  logic          ptr_err;

  modport master (
    output wr_en, rptr_sync, af_thr_ld, af_thr, clr_err,
    input  wr_accept, waddr, wptr, wptr_gray, level, full, almost_full,
           wrap_pulse, wrap_dly, overflow, ptr_err
  );

  modport slave (
    input  wr_en, rptr_sync, af_thr_ld, af_thr, clr_err,
    output wr_accept, waddr, wptr, wptr_gray, level, full, almost_full,
           wrap_pulse, wrap_dly, overflow, ptr_err
  );

endinterface

// File: rtl/fifo_wptr_wrap_ctrl_ptr_gray_enc.sv
// Registered binary-to-Gray pointer encoder, shared by both FIFO pointer
// controllers. Feed it the next-state pointer so gray_o lines up with the
// registered binary pointer on the same edge.
//  clk_i  in  1  clock
//  rst_i  in  1  synchronous active-high reset (gray_o -> 0)
//  bin_i  in  W  binary pointer (next-state value)
//  gray_o out W  registered Gray code of bin_i
module fifo_wptr_wrap_ctrl_ptr_gray_enc
  import fifo_wptr_wrap_ctrl_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  logic [W-1:0] gray_q;
  logic [W-1:0] gray_d;

  always_comb begin
    gray_d = W'(bin2gray(PTR_MAX_W'(bin_i)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/fifo_wptr_wrap_ctrl.sv
// Write-side pointer and status controller for the FIFO (clk_w domain only).
// Owns the binary write pointer (with wrap bit), takes the read pointer already
// synchronised into clk_w, and produces registered level/full/almost-full,
// a wrap pulse, a delayed wrap indication and sticky error flags.
//  clk_w  in  1  write clock
//  rst_w  in  1  synchronous active-high reset; wins over every other input
//  bus    slave modport of fifo_wptr_wrap_ctrl_if (DEPTH must match)
// Parameters: DEPTH (power of 2, >= 4), NDLY (1..4 wrap_dly stages),
//             AF_RST (almost-full threshold after reset, 1..DEPTH).
module fifo_wptr_wrap_ctrl
  import fifo_wptr_wrap_ctrl_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NDLY   = 1,
  parameter int AF_RST = DEPTH - 2
) (
  input logic                   clk_w,
  input logic                   rst_w,
  fifo_wptr_wrap_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0]   DEPTH_P   = PW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  // An out-of-range reset threshold is treated like an out-of-range load.
  localparam logic [AW:0]   AF_RST_P  =
    ((AF_RST < 1) || (AF_RST > DEPTH)) ? DEPTH_P : PW'(AF_RST);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_wptr_wrap_ctrl: DEPTH must be a power of two >= 4");
  end
  if (!ndly_ok(NDLY)) begin : g_bad_ndly
    $error("fifo_wptr_wrap_ctrl: NDLY must be in 1..4");
  end

  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     level_q;
  logic [AW:0]     lvl_nxt;
  logic [AW:0]     af_thr_q, af_thr_d;
  wflags_t         flags_q, flags_d;
  logic            wr_accept;
  logic            wrap_a;
  logic [NDLY-1:0] dly_q;
  logic [NDLY-1:0] dly_in;
  logic [AW:0]     wptr_gray;

  always_comb begin
    wr_accept = bus.wr_en & ~flags_q.full;
    wptr_d    = wptr_q + {{AW{1'b0}}, wr_accept};
    // Modular subtract: a read pointer ahead of the write pointer shows up as
    // a level above DEPTH, which is how ptr_err detects corruption.
    lvl_nxt   = wptr_d - bus.rptr_sync;
    // Uses the registered almost_full, not the next-state one.
    wrap_a    = flags_q.almost_full & (bus.rptr_sync[AW-1:0] > wptr_q[AW-1:0]);

    af_thr_d = af_thr_q;
    if (bus.af_thr_ld) begin
      if ((bus.af_thr == '0) || (bus.af_thr > DEPTH_P)) begin
        af_thr_d = DEPTH_P;
      end else begin
        af_thr_d = bus.af_thr;
      end
    end

    flags_d             = flags_q;
    flags_d.full        = (lvl_nxt == DEPTH_P);
    flags_d.almost_full = (lvl_nxt >= af_thr_q);
    flags_d.wrap_pulse  = wr_accept & (wptr_q[AW-1:0] == LAST_ADDR);
    // Sticky errors: a set condition beats a simultaneous clear.
    flags_d.overflow    = (flags_q.overflow & ~bus.clr_err) | (bus.wr_en & flags_q.full);
    flags_d.ptr_err     = (flags_q.ptr_err  & ~bus.clr_err) | (lvl_nxt > DEPTH_P);
  end

  // wrap_A delay line: stage 0 takes wrap_a, each later stage the one before.
  assign dly_in[0] = wrap_a;
  for (genvar i = 1; i < NDLY; i++) begin : g_dly
    assign dly_in[i] = dly_q[i-1];
  end

  always_ff @(posedge clk_w) begin
    if (rst_w) begin
      wptr_q   <= '0;
      level_q  <= '0;
      flags_q  <= '0;
      dly_q    <= '0;
      af_thr_q <= AF_RST_P;
    end else begin
      wptr_q   <= wptr_d;
      level_q  <= lvl_nxt;
      flags_q  <= flags_d;
      dly_q    <= dly_in;
      af_thr_q <= af_thr_d;
    end
  end

  // Encoding wptr_d keeps wptr_gray in step with wptr on every edge.
  fifo_wptr_wrap_ctrl_ptr_gray_enc #(
    .W (PW)
  ) u_gray_enc (
    .clk_i  (clk_w),
    .rst_i  (rst_w),
    .bin_i  (wptr_d),
    .gray_o (wptr_gray)
  );

  assign bus.wr_accept   = wr_accept;
  assign bus.waddr       = wptr_q[AW-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.wptr_gray   = wptr_gray;
  assign bus.level       = level_q;
  assign bus.full        = flags_q.full;
  assign bus.almost_full = flags_q.almost_full;
  assign bus.wrap_pulse  = flags_q.wrap_pulse;
  assign bus.wrap_dly    = dly_q[NDLY-1];
  assign bus.overflow    = flags_q.overflow;
  assign bus.ptr_err     = flags_q.ptr_err;

endmodule
